// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller port among CPU, DMA and video: video has fixed priority, and CPU/DMA take turns round-robin.
// One transaction is outstanding at a time; ack is a one-cycle pulse after completion; a watchdog aborts stalled transfers.
module sdram_arbiter #(
  parameter int          TIMEOUT_BITS = 8,
  parameter logic [31:0] ERR_DATA     = 32'hffffffff
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        cpu_req,
  input  logic        cpu_write,
  input  logic [21:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_ack,
  output logic [31:0] cpu_rdata,

  input  logic        dma_req,
  input  logic        dma_write,
  input  logic [21:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_ack,
  output logic [31:0] dma_rdata,

  input  logic        vga_req,
  input  logic [21:0] vga_addr,
  output logic        vga_ack,
  output logic [31:0] vga_rdata,

  output logic [21:0] sdram_addr,
  output logic [31:0] sdram_data_out,
  input  logic [31:0] sdram_data_in,
  output logic        sdram_req,
  output logic        sdram_write,
  input  logic        sdram_ready,
  input  logic        sdram_done,

  output logic [1:0]  grant,
  output logic        timeout_err
);

  typedef enum logic [1:0] {IDLE, BUSY, COMPLETE} state_t;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_CPU  = 2'd1;
  localparam logic [1:0] G_DMA  = 2'd2;
  localparam logic [1:0] G_VGA  = 2'd3;

  // Abort fires on the edge where the counter would reach all-ones.
  localparam logic [TIMEOUT_BITS-1:0] WD_LAST = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};

  state_t                  state;
  logic                    is_write;
  logic                    rr_dma;
  logic [TIMEOUT_BITS-1:0] wd;

  logic [1:0]  winner;
  logic [21:0] win_addr;
  logic [31:0] win_wdata;
  logic        win_write;
  logic        xfer_done;
  logic        wd_expired;
  logic        finish;
  logic [31:0] fin_data;

  always_comb begin
    winner = G_NONE;
    if (vga_req)                 winner = G_VGA;
    else if (cpu_req && dma_req) winner = rr_dma ? G_DMA : G_CPU;
    else if (cpu_req)            winner = G_CPU;
    else if (dma_req)            winner = G_DMA;
  end

  always_comb begin
    win_addr  = vga_addr;
    win_wdata = '0;
    win_write = 1'b0;
    case (winner)
      G_CPU: begin
        win_addr  = cpu_addr;
        win_wdata = cpu_wdata;
        win_write = cpu_write;
      end
      G_DMA: begin
        win_addr  = dma_addr;
        win_wdata = dma_wdata;
        win_write = dma_write;
      end
      default: ;
    endcase
  end

  // Only the completion matching the current direction counts.
  assign xfer_done  = is_write ? sdram_done : sdram_ready;
  assign wd_expired = (wd == WD_LAST);
  assign finish     = xfer_done || wd_expired;
  assign fin_data   = xfer_done ? sdram_data_in : ERR_DATA;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      is_write       <= 1'b0;
      rr_dma         <= 1'b0;
      wd             <= '0;
      grant          <= G_NONE;
      sdram_addr     <= '0;
      sdram_data_out <= '0;
      sdram_req      <= 1'b0;
      sdram_write    <= 1'b0;
      timeout_err    <= 1'b0;
      cpu_ack        <= 1'b0;
      dma_ack        <= 1'b0;
      vga_ack        <= 1'b0;
      cpu_rdata      <= '0;
      dma_rdata      <= '0;
      vga_rdata      <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      vga_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (winner != G_NONE) begin
            grant          <= winner;
            sdram_addr     <= win_addr;
            sdram_data_out <= win_wdata;
            is_write       <= win_write;
            sdram_req      <= !win_write;
            sdram_write    <= win_write;
            wd             <= '0;
            state          <= BUSY;
          end
        end
        BUSY: begin
          if (finish) begin
            sdram_req   <= 1'b0;
            sdram_write <= 1'b0;
            if (!xfer_done) timeout_err <= 1'b1;
            if (!is_write) begin
              case (grant)
                G_CPU:   cpu_rdata <= fin_data;
                G_DMA:   dma_rdata <= fin_data;
                G_VGA:   vga_rdata <= fin_data;
                default: ;
              endcase
            end
            case (grant)
              G_CPU:   cpu_ack <= 1'b1;
              G_DMA:   dma_ack <= 1'b1;
              G_VGA:   vga_ack <= 1'b1;
              default: ;
            endcase
            state <= COMPLETE;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        COMPLETE: begin
          if (grant == G_CPU)      rr_dma <= 1'b1;
          else if (grant == G_DMA) rr_dma <= 1'b0;
          grant <= G_NONE;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port (22-bit word address, 32-bit data, read strobe/ready, write strobe/done) among three requesters: CPU xbus RAM path, VGA/TV scanline fetch (read-only), disk DMA.
- Fixed priority for video; round-robin between CPU and DMA; one transaction outstanding at a time.
- Watchdog aborts transactions the controller never completes.
- Sits between the xbus RAM decode logic and the SDRAM controller.

Parameters:
TIMEOUT_BITS, 8, width of watchdog counter; abort when counter reaches all-ones (255 cycles).
ERR_DATA, 32'hffffffff, read data returned on an aborted read.

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
cpu_req  in  1  CPU request, held until cpu_ack
cpu_write  in  1  1=write, 0=read; stable while cpu_req
cpu_addr  in  22  CPU word address
cpu_wdata  in  32  CPU write data
cpu_ack  out  1  one-cycle completion pulse
cpu_rdata  out  32  CPU read data, valid from cpu_ack, held until next CPU read completes
dma_req  in  1  DMA request, same rules as CPU
dma_write  in  1  DMA direction
dma_addr  in  22  DMA address
dma_wdata  in  32  DMA write data
dma_ack  out  1  completion pulse
dma_rdata  out  32  DMA read data, held as cpu_rdata
vga_req  in  1  video read request
vga_addr  in  22  video address
vga_ack  out  1  completion pulse
vga_rdata  out  32  video read data, held
sdram_addr  out  22  registered address to controller
sdram_data_out  out  32  registered write data
sdram_data_in  in  32  read data, valid when sdram_ready
sdram_req  out  1  read strobe, held until sdram_ready
sdram_write  out  1  write strobe, held until sdram_done
sdram_ready  in  1  read complete
sdram_done  in  1  write complete
grant  out  2  owner: 0 none, 1 CPU, 2 DMA, 3 VGA
timeout_err  out  1  sticky; set on any abort

Behaviour:
- Reset (reset low, asynchronous): state IDLE; all acks, sdram_req, sdram_write, timeout_err = 0; grant = 0; sdram_addr, sdram_data_out, all rdata = 0; rr pointer = CPU; watchdog = 0.
- States: IDLE, BUSY, COMPLETE.
- IDLE:
  - If any req is high, select the winner:
    - vga_req wins over all.
    - Otherwise, if both cpu_req and dma_req are high, the port not granted last wins (rr pointer).
    - Otherwise the single requester wins.
  - Register the winner's addr, wdata and direction; set grant.
  - Assert sdram_req (read) or sdram_write (write) on the next cycle; go to BUSY; clear watchdog.
- BUSY:
  - Hold strobe, addr and data stable.
  - Completion condition: sdram_ready sampled high (read) or sdram_done sampled high (write). Opposite-direction completion is ignored.
  - On read completion, latch sdram_data_in into the owner's rdata.
  - On completion, drop the strobe and go to COMPLETE.
  - Otherwise increment watchdog. When watchdog is all-ones: drop strobe, set timeout_err, load ERR_DATA into the owner's rdata on reads (write data is discarded), go to COMPLETE.
- COMPLETE:
  - Owner's ack = 1 for exactly one cycle.
  - Update rr pointer only if the owner is CPU or DMA.
  - grant returns to 0; go to IDLE.
- Requester rule: deassert req at the edge where ack is sampled. A req still high in IDLE is a new request.
- Latency: request visible at edge N → strobe high from cycle N+1 → completion sampled at edge M → ack high during cycle M+1. Minimum req-to-ack is 3 cycles.
- No preemption. A video request arriving during BUSY waits; it wins the next IDLE even if CPU/DMA are pending.
- A request dropping during BUSY does not abort; ack is still issued.
- Reset asserted mid-transaction: strobe drops immediately; no ack is issued.
- Each ack output depends only on its own port; at most one ack is high per cycle.
- grant and acks are registered; no combinational path from any input to an output.

Test Plan:
- Single CPU read @22'o1234 with controller ready after 4 cycles, data 32'hdeadbeef → sdram_req high 4 cycles, grant=1, cpu_ack one pulse 1 cycle after ready, cpu_rdata=32'hdeadbeef.
- CPU and DMA both request writes continuously, three transactions each → grants alternate CPU, DMA, CPU, DMA…; each sdram_write matches the owner's addr/wdata.
- VGA, CPU and DMA request simultaneously in IDLE → VGA served first; then CPU and DMA per rr pointer; VGA raised during the CPU transaction is served before DMA.
- Controller never asserts sdram_ready for a DMA read → abort after 255 BUSY cycles; dma_ack pulse; dma_rdata=32'hffffffff; timeout_err=1 and stays 1.
- Write in BUSY with a spurious sdram_ready → ignored; completes only on sdram_done.
- Assert reset low mid-BUSY → sdram_write, grant, acks = 0 immediately; after release, IDLE accepts a new request normally.
